// File: rtl/sync_data_sink.sv
// Destination-side sink for the data_sync channel: strobed words into a small FIFO, out via valid/ready.
// Optional SYNC_SINK_DROP_CNT_EN adds a saturating drop_cnt output counting discarded strobes.
module sync_data_sink #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     dclk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     ready,
  input  logic [WIDTH-1:0]         sync_data,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
`ifdef SYNC_SINK_DROP_CNT_EN
  output logic [7:0]               drop_cnt,
`endif
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             overflow_q, overflow_d;
  logic             push, pop, drop;

  // Pointers carry a wrap bit so full and empty differ without a spare slot.
  assign level     = wr_q - rd_q;
  assign full      = (level == (AW+1)'(DEPTH));
  assign out_valid = (wr_q != rd_q);
  assign out_data  = mem_q[rd_q[AW-1:0]];
  assign overflow  = overflow_q;

  assign pop  = out_valid & out_ready;
  assign push = ready & (~full | pop);
  assign drop = ready & ~push;

  always_comb begin
    wr_d       = wr_q;
    rd_d       = rd_q;
    mem_d      = mem_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_d       = '0;
      rd_d       = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_q[AW-1:0]] = sync_data;
        wr_d                = wr_q + (AW+1)'(1);
      end
      if (pop) rd_d = rd_q + (AW+1)'(1);
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

`ifdef SYNC_SINK_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr)                              drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sync_data_sink.sv
// Scoreboard bench for sync_data_sink: a queue model of the FIFO is updated by the stimulus,
// and an independent monitor compares status and popped words each cycle.
module tb_sync_data_sink;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             dclk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] sync_data = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;
  logic             full;
  logic             overflow;
`ifdef SYNC_SINK_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  sync_data_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .dclk(dclk), .rst(rst), .clr(clr), .ready(ready), .sync_data(sync_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .full(full),
`ifdef SYNC_SINK_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .overflow(overflow)
  );

  always #5 dclk = ~dclk;

  int checks = 0;
  int passed = 0;
  logic [WIDTH-1:0] exp_q[$];
  bit ovf_m = 1'b0;
  int drop_m = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  // One clock of stimulus; the model state is advanced at the edge.
  task automatic cycle(input bit c, input bit r, input logic [WIDTH-1:0] d, input bit ordy);
    int sz;
    bit pop, push;
    @(negedge dclk);
    clr = c; ready = r; sync_data = d; out_ready = ordy;
    sz   = exp_q.size();
    pop  = (sz > 0) && ordy;
    push = r && ((sz < DEPTH) || pop);
    @(posedge dclk);
    if (c) begin
      exp_q.delete();
      ovf_m  = 1'b0;
      drop_m = 0;
    end else if (push) begin
      exp_q.push_back(d);
    end else if (r) begin
      ovf_m = 1'b1;
      if (drop_m < 255) drop_m++;
    end
  endtask

  // Async reset pulse placed between clock edges.
  task automatic reset_pulse();
    @(negedge dclk);
    clr = 1'b0; ready = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    exp_q.delete();
    ovf_m  = 1'b0;
    drop_m = 0;
    #2 rst = 1'b0;
  endtask

  // Monitor: inputs are settled 2 time units after the falling edge.
  initial begin
    logic [WIDTH-1:0] w;
    forever begin
      @(negedge dclk);
      #2;
      if (mon_en) begin
        chk("level", int'(level), exp_q.size());
        chk("out_valid", int'(out_valid), int'(exp_q.size() > 0));
        chk("full", int'(full), int'(exp_q.size() == DEPTH));
        chk("overflow", int'(overflow), int'(ovf_m));
`ifdef SYNC_SINK_DROP_CNT_EN
        chk("drop_cnt", int'(drop_cnt), drop_m);
`endif
        if (exp_q.size() > 0 && out_ready) begin
          w = exp_q.pop_front();
          chk("out_data", int'(out_data), int'(w));
        end
      end
    end
  end

  initial begin
    int ordy_pct;
    #12 rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_out_data", int'(out_data), 0);
    mon_en = 1'b1;

    // single word
    cycle(0, 1, 8'h0A, 1);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 1);

    // fill and drain
    for (int i = 1; i <= 4; i++) cycle(0, 1, WIDTH'(i), 0);
    cycle(0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1);

    // overflow while full, then drain and clear
    for (int i = 1; i <= 4; i++) cycle(0, 1, WIDTH'(i), 0);
    cycle(0, 1, 8'hFF, 0);
    cycle(0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 0);

    // full push + pop in the same cycle
    for (int i = 1; i <= 4; i++) cycle(0, 1, WIDTH'(i), 0);
    cycle(0, 1, 8'h55, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1);

    // clr with a coinciding strobe, then async reset mid-burst
    for (int i = 1; i <= 3; i++) cycle(0, 1, WIDTH'(8'h10 + i), 0);
    cycle(1, 1, 8'hAA, 0);
    cycle(0, 0, 8'h00, 0);
    for (int i = 1; i <= 3; i++) cycle(0, 1, WIDTH'(8'h20 + i), 0);
    reset_pulse();
    cycle(0, 1, 8'h33, 0);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 0);

    // randomized traffic with varying downstream back-pressure
    ordy_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) ordy_pct = $urandom_range(0, 100);
      if (n % 500 == 250) reset_pulse();
      cycle($urandom_range(0, 63) == 0,
            $urandom_range(0, 1) == 1,
            WIDTH'($urandom),
            $urandom_range(1, 100) <= ordy_pct);
    end
    cycle(0, 0, 8'h00, 1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
